cache_ctrl_sa: RTL and testbench

//  Parametrised set-associative, write-through, read-allocate cache controller with internal tag/data arrays.

---
 rtl/cache_ctrl_sa.sv | 215 +++++++++++++++++++++
 tb/tb_cache_ctrl_sa.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_ctrl_sa.sv
// cache_ctrl_sa: set-associative, write-through, read-allocate cache controller with pseudo-LRU replacement.
// Define CACHE_STATS_EN to add the hit_count/miss_count statistics ports.
module cache_ctrl_sa #(
    parameter int ADDR_W    = 32,
    parameter int BASE_ADDR = 1024,
    parameter int SETS      = 64,
    parameter int WAYS      = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] address,
    input  logic [31:0]       wdata,
    input  logic              mem_r_en,
    input  logic              mem_w_en,
    input  logic [63:0]       sram_rdata,
    input  logic              sram_ready,
    output logic [31:0]       rdata,
    output logic              ready,
    output logic [ADDR_W-1:0] sram_address,
    output logic [31:0]       sram_wdata,
    output logic              sram_read,
    output logic              sram_write
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0]       hit_count,
    output logic [31:0]       miss_count
`endif
);
    localparam int SET_W = $clog2(SETS);
    localparam int TAG_W = ADDR_W - SET_W - 3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RMISS = 2'd1,
        S_WRITE = 2'd2
    } state_t;

    state_t            state_r;
    state_t            next_state_s;

    logic              valid_r [WAYS][SETS];
    logic [TAG_W-1:0]  tag_r   [WAYS][SETS];
    logic [63:0]       data_r  [WAYS][SETS];
    logic              lru_r   [SETS];

    logic [ADDR_W-1:0] off_s;
    logic              word_s;
    logic [SET_W-1:0]  set_s;
    logic [TAG_W-1:0]  tag_s;
    logic              hit_s;
    logic              hit_way_s;
    logic [63:0]       hit_line_s;
    logic              victim_s;
    logic              fill_s;
    logic              wr_upd_s;
    logic              touch_s;
    logic              unused_off_s;

    assign off_s        = address - ADDR_W'(BASE_ADDR);
    assign word_s       = off_s[2];
    assign set_s        = off_s[SET_W+2:3];
    assign tag_s        = off_s[ADDR_W-1:SET_W+3];
    assign unused_off_s = ^off_s[1:0];

    // Tag compare across all ways of the addressed set.
    always_comb begin
        hit_s      = 1'b0;
        hit_way_s  = 1'b0;
        hit_line_s = 64'd0;
        for (int w = 0; w < WAYS; w++) begin
            if (!hit_s && valid_r[w][set_s] && (tag_r[w][set_s] == tag_s)) begin
                hit_s      = 1'b1;
                hit_way_s  = 1'(w);
                hit_line_s = data_r[w][set_s];
            end else begin
                hit_s      = hit_s;
            end
        end
    end

    // Victim choice: first invalid way, otherwise the way the LRU bit points at.
    always_comb begin
        if (WAYS == 1) begin
            victim_s = 1'b0;
        end else if (!valid_r[0][set_s]) begin
            victim_s = 1'b0;
        end else if (!valid_r[WAYS-1][set_s]) begin
            victim_s = 1'b1;
        end else begin
            victim_s = lru_r[set_s];
        end
    end

    // Next-state decode and request/SRAM handshake outputs.
    always_comb begin
        next_state_s = state_r;
        ready        = 1'b0;
        rdata        = 32'd0;
        sram_read    = 1'b0;
        sram_write   = 1'b0;
        sram_address = {ADDR_W{1'b0}};
        sram_wdata   = 32'd0;
        fill_s       = 1'b0;
        wr_upd_s     = 1'b0;
        touch_s      = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (mem_w_en) begin
                    next_state_s = S_WRITE;
                end else if (mem_r_en) begin
                    if (hit_s) begin
                        ready   = 1'b1;
                        rdata   = word_s ? hit_line_s[63:32] : hit_line_s[31:0];
                        touch_s = 1'b1;
                    end else begin
                        next_state_s = S_RMISS;
                    end
                end else begin
                    ready = 1'b1;
                end
            end
            S_RMISS: begin
                sram_read    = 1'b1;
                sram_address = address;
                if (sram_ready) begin
                    ready        = 1'b1;
                    rdata        = word_s ? sram_rdata[63:32] : sram_rdata[31:0];
                    fill_s       = 1'b1;
                    next_state_s = S_IDLE;
                end else begin
                    next_state_s = S_RMISS;
                end
            end
            S_WRITE: begin
                sram_write   = 1'b1;
                sram_address = address;
                sram_wdata   = wdata;
                if (sram_ready) begin
                    ready        = 1'b1;
                    wr_upd_s     = hit_s;
                    next_state_s = S_IDLE;
                end else begin
                    next_state_s = S_WRITE;
                end
            end
            default: begin
                next_state_s = S_IDLE;
            end
        endcase
    end

    // Controller state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Valid and LRU bits; an asynchronous reset invalidates the whole cache.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int s = 0; s < SETS; s++) begin
                lru_r[s] <= 1'b0;
                for (int w = 0; w < WAYS; w++) begin
                    valid_r[w][s] <= 1'b0;
                end
            end
        end else begin
            if (fill_s) begin
                valid_r[victim_s][set_s] <= 1'b1;
            end
            if (WAYS > 1) begin
                if (touch_s || wr_upd_s) begin
                    lru_r[set_s] <= ~hit_way_s;
                end else if (fill_s) begin
                    lru_r[set_s] <= ~victim_s;
                end
            end
        end
    end

    // Tag/data storage needs no reset: contents are only observed behind a valid bit.
    always_ff @(posedge clk) begin
        if (fill_s) begin
            tag_r[victim_s][set_s]  <= tag_s;
            data_r[victim_s][set_s] <= sram_rdata;
        end else if (wr_upd_s) begin
            if (word_s) begin
                data_r[hit_way_s][set_s][63:32] <= wdata;
            end else begin
                data_r[hit_way_s][set_s][31:0]  <= wdata;
            end
        end
    end

`ifdef CACHE_STATS_EN
    // Read hit/miss statistics, wrapping at 2^32.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_count  <= 32'd0;
            miss_count <= 32'd0;
        end else begin
            if (touch_s) begin
                hit_count <= hit_count + 32'd1;
            end
            if ((state_r == S_IDLE) && (next_state_s == S_RMISS)) begin
                miss_count <= miss_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_cache_ctrl_sa.sv
// Self-checking bench for cache_ctrl_sa: recency-ordered set model plus a word-level memory image.
// Build with CACHE_STATS_EN defined to also check the statistics counters.
module tb_cache_ctrl_sa;
    logic        clk;
    logic        rst;
    logic [31:0] address;
    logic [31:0] wdata;
    logic        mem_r_en;
    logic        mem_w_en;
    logic [63:0] sram_rdata;
    logic        sram_ready;
    logic [31:0] rdata;
    logic        ready;
    logic [31:0] sram_address;
    logic [31:0] sram_wdata;
    logic        sram_read;
    logic        sram_write;
`ifdef CACHE_STATS_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    cache_ctrl_sa #(.ADDR_W(32), .BASE_ADDR(1024), .SETS(64), .WAYS(2)) dut (
        .clk(clk), .rst(rst), .address(address), .wdata(wdata),
        .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
        .sram_rdata(sram_rdata), .sram_ready(sram_ready),
        .rdata(rdata), .ready(ready), .sram_address(sram_address),
        .sram_wdata(sram_wdata), .sram_read(sram_read), .sram_write(sram_write)
`ifdef CACHE_STATS_EN
        , .hit_count(hit_count), .miss_count(miss_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_hits = 0;
    int exp_misses = 0;

    // Memory image behind the SRAM; untouched words read back a fixed hash.
    logic [31:0] mem [bit [31:0]];
    // Per set: most-recent tag, least-recent tag, and number of resident lines (0..2).
    logic [22:0] mru_tag [64];
    logic [22:0] lru_tag [64];
    int          cnt     [64];

    function automatic logic [31:0] rd_mem(input bit [31:0] a);
        if (mem.exists(a)) return mem[a];
        return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
    endfunction

    function automatic bit model_hit(input int s, input logic [22:0] t);
        return (cnt[s] >= 1 && mru_tag[s] == t) || (cnt[s] >= 2 && lru_tag[s] == t);
    endfunction

    function automatic void model_touch(input int s, input logic [22:0] t);
        if (mru_tag[s] != t) begin
            lru_tag[s] = mru_tag[s];
            mru_tag[s] = t;
        end
    endfunction

    function automatic void model_insert(input int s, input logic [22:0] t);
        if (cnt[s] >= 1) lru_tag[s] = mru_tag[s];
        mru_tag[s] = t;
        if (cnt[s] < 2) cnt[s] = cnt[s] + 1;
    endfunction

    function automatic void model_clear();
        for (int s = 0; s < 64; s++) cnt[s] = 0;
        exp_hits   = 0;
        exp_misses = 0;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One request, starting and ending 1 time unit after a rising edge; checks every cycle.
    task automatic do_req(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                          input int dly, output logic [31:0] rd_o, output int busy_o);
        logic [31:0] off;
        int          s;
        logic [22:0] t;
        bit          hit;
        logic [31:0] exp_rd;
        logic [63:0] line;
        off    = addr - 32'd1024;
        s      = int'(off[8:3]);
        t      = off[31:9];
        hit    = model_hit(s, t);
        exp_rd = rd_mem(addr);
        line   = {rd_mem((addr & ~32'h7) + 32'd4), rd_mem(addr & ~32'h7)};
        rd_o   = 32'd0;
        busy_o = 0;
        address    = addr;
        wdata      = wd;
        mem_r_en   = !wr;
        mem_w_en   = wr;
        sram_ready = 1'($urandom_range(0, 1));
        sram_rdata = {$urandom, $urandom};
        @(negedge clk);
        if (!wr && hit) begin
            chk("hit_ready", ready, 1);
            chk("hit_rdata", rdata, exp_rd);
            chk("hit_no_sram", {sram_read, sram_write}, 0);
            chk("hit_sram_addr", sram_address, 0);
            rd_o = rdata;
            model_touch(s, t);
            exp_hits++;
        end else begin
            chk("idle_wait", ready, 0);
            chk("idle_strobes", {sram_read, sram_write}, 0);
            if (!wr) exp_misses++;
            for (int k = 1; k <= dly; k++) begin
                @(posedge clk); #1;
                sram_ready = (k == dly);
                sram_rdata = (k == dly && !wr) ? line : {$urandom, $urandom};
                @(negedge clk);
                if (sram_read || sram_write) busy_o++;
                chk("sram_read", sram_read, !wr);
                chk("sram_write", sram_write, wr);
                chk("sram_address", sram_address, addr);
                chk("sram_wdata", sram_wdata, wr ? wd : 32'd0);
                chk("busy_ready", ready, (k == dly));
                if (k == dly && !wr) begin
                    chk("miss_rdata", rdata, exp_rd);
                    rd_o = rdata;
                end
            end
            if (wr) begin
                mem[addr] = wd;
                if (hit) model_touch(s, t);
            end else begin
                model_insert(s, t);
            end
        end
        @(posedge clk); #1;
        mem_r_en   = 1'b0;
        mem_w_en   = 1'b0;
        sram_ready = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            sram_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("idle_ready", ready, 1);
            chk("idle_no_sram", {sram_read, sram_write}, 0);
            chk("idle_addr", sram_address, 0);
            chk("idle_wdata", sram_wdata, 0);
            @(posedge clk); #1;
        end
        sram_ready = 1'b0;
    endtask

    logic [31:0] rd;
    int          busy;

    initial begin
        rst        = 1'b0;
        address    = 32'd0;
        wdata      = 32'd0;
        mem_r_en   = 1'b0;
        mem_w_en   = 1'b0;
        sram_rdata = 64'd0;
        sram_ready = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", ready, 1);
        chk("rst_strobes", {sram_read, sram_write}, 0);
        chk("rst_addr", sram_address, 0);
        chk("rst_wdata", sram_wdata, 0);
        chk("rst_rdata", rdata, 0);
`ifdef CACHE_STATS_EN
        chk("rst_hits", hit_count, 0);
        chk("rst_misses", miss_count, 0);
`endif
        @(posedge clk); #1;
        rst = 1'b1;

        // Cold miss with a 3-cycle SRAM read, then a hit on the other word.
        mem[32'h400] = 32'h11111111;
        mem[32'h404] = 32'h22222222;
        do_req(1'b0, 32'h400, 32'd0, 3, rd, busy);
        chk("s1_rdata", rd, 32'h11111111);
        chk("s1_read_cycles", busy, 3);
        do_req(1'b0, 32'h404, 32'd0, 1, rd, busy);
        chk("s1_hit_rdata", rd, 32'h22222222);
        chk("s1_hit_busy", busy, 0);
`ifdef CACHE_STATS_EN
        chk("s6_hits", hit_count, 1);
        chk("s6_misses", miss_count, 1);
`endif

        // Write hit updates the cached word in place.
        do_req(1'b1, 32'h400, 32'hDEADBEEF, 2, rd, busy);
        chk("s2_write_cycles", busy, 2);
        do_req(1'b0, 32'h400, 32'd0, 1, rd, busy);
        chk("s2_rdata", rd, 32'hDEADBEEF);
        chk("s2_hit_busy", busy, 0);

        // Write miss does not allocate.
        do_req(1'b1, 32'h480, 32'h5, 1, rd, busy);
        do_req(1'b0, 32'h480, 32'd0, 2, rd, busy);
        chk("s3_read_miss", (busy > 0), 1);
        chk("s3_rdata", rd, 32'h5);

        // LRU eviction within set 0.
        do_req(1'b0, 32'h400, 32'd0, 1, rd, busy);
        do_req(1'b0, 32'h600, 32'd0, 2, rd, busy);
        do_req(1'b0, 32'h400, 32'd0, 1, rd, busy);
        do_req(1'b0, 32'h800, 32'd0, 3, rd, busy);
        chk("s4_c_miss", (busy > 0), 1);
        do_req(1'b0, 32'h400, 32'd0, 1, rd, busy);
        chk("s4_a_hit", busy, 0);
        do_req(1'b0, 32'h600, 32'd0, 1, rd, busy);
        chk("s4_b_miss", (busy > 0), 1);
        idle_cycles(2);

        // Reset in the middle of a read miss.
        do_req(1'b0, 32'h400, 32'd0, 1, rd, busy);
        chk("s5_a_cached", busy, 0);
        address  = 32'hA00;
        mem_r_en = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("s5_read_active", sram_read, 1);
        #2 rst = 1'b0;
        #1;
        chk("s5_read_drop", sram_read, 0);
        chk("s5_addr_drop", sram_address, 0);
        @(posedge clk); #1;
        mem_r_en = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        model_clear();
        do_req(1'b0, 32'h400, 32'd0, 2, rd, busy);
        chk("s5_a_miss", (busy > 0), 1);
        chk("s5_a_rdata", rd, 32'hDEADBEEF);

        // Randomised traffic over 4 sets x 4 tags to exercise conflicts.
        for (int n = 0; n < 400; n++) begin
            logic [31:0] a;
            bit          wr;
            a  = 32'h400 + (32'($urandom_range(0, 3)) << 9) + (32'($urandom_range(0, 3)) << 3)
                 + (32'($urandom_range(0, 1)) << 2);
            wr = ($urandom_range(0, 9) < 3);
            do_req(wr, a, $urandom, $urandom_range(1, 4), rd, busy);
            if ($urandom_range(0, 3) == 0) idle_cycles($urandom_range(1, 2));
        end

`ifdef CACHE_STATS_EN
        chk("end_hits", hit_count, 32'(exp_hits));
        chk("end_misses", miss_count, 32'(exp_misses));
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
